// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard host controller.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    // Prefix decoder state: which prefixes have been seen for the key in flight.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    // One decoded key event as stored in the FIFO.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchronises the pins, detects ps2_clk falling edges and
// deframes 11-bit frames into bytes with a one-cycle strobe or an error pulse.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_frame_err
);

    localparam int          TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [1:0]       r_clk_sync;
    logic [1:0]       r_data_sync;
    logic             r_clk_prev;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_stb;
    logic             r_err;
    logic             w_fall;
    logic             w_data;

    assign w_fall      = r_clk_prev & ~r_clk_sync[1];
    assign w_data      = r_data_sync[1];
    assign o_byte      = r_shift;
    assign o_byte_stb  = r_stb;
    assign o_frame_err = r_err;

    // Two-flop synchronisers (preset to idle-high) plus previous clock sample for edge detect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // Bit counter, LSB-first shift, parity/stop check and mid-frame timeout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tmo_cnt <= '0;
            r_stb     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            r_err <= 1'b0;
            if (w_fall) begin
                r_tmo_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    // A high start bit is line noise, not a frame.
                    if (!w_data) r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {w_data, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt < LAST_BIT) begin
                    r_par     <= w_data;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else begin
                    r_bit_cnt <= '0;
                    if ((^{r_shift, r_par}) && w_data) r_stb <= 1'b1;
                    else                               r_err <= 1'b1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_tmo_cnt == TMO_LAST) begin
                    // Keyboard went quiet mid-frame: drop the partial byte silently.
                    r_bit_cnt <= '0;
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard host controller: frame receiver, E0/F0 prefix decoder and an
// event FIFO read through a valid/ready handshake.
// Handshake: an event transfers on a clock edge where evt_valid and evt_ready
// are both 1; evt_* hold the head steady while evt_valid=1 and evt_ready=0.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       overflow,
    output logic       parity_err,
    input  logic       clr_err,
    output logic [1:0] dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  w_byte;
    logic        w_byte_stb;
    logic        w_frame_err;
    dec_state_t  r_state;
    dec_state_t  w_next_state;
    logic        w_is_brk;
    logic        w_is_ext;
    logic        w_emit;
    kbd_evt_t    w_emit_evt;
    logic        r_push;
    kbd_evt_t    r_push_evt;
    kbd_evt_t    r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr_en;
    logic        w_ovf_set;
    kbd_evt_t    w_head;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_byte      (w_byte),
        .o_byte_stb  (w_byte_stb),
        .o_frame_err (w_frame_err)
    );

    assign w_is_brk  = (w_byte == PS2_BREAK);
    assign w_is_ext  = (w_byte == PS2_EXT);
    assign dbg_state = r_state;

    // Decoder state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Decoder next state: prefixes accumulate, any other byte finishes the key.
    always_comb begin
        w_next_state = r_state;
        if (w_byte_stb) begin
            case (r_state)
                IDLE:    w_next_state = w_is_ext ? EXT : (w_is_brk ? BRK : IDLE);
                EXT:     w_next_state = w_is_brk ? EXT_BRK : (w_is_ext ? EXT : IDLE);
                BRK:     w_next_state = w_is_brk ? BRK : (w_is_ext ? EXT_BRK : IDLE);
                EXT_BRK: w_next_state = (w_is_brk || w_is_ext) ? EXT_BRK : IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Decoder output: a non-prefix byte emits an event tagged with the prefixes seen.
    always_comb begin
        w_emit          = w_byte_stb && !w_is_brk && !w_is_ext;
        w_emit_evt.ext  = (r_state == EXT) || (r_state == EXT_BRK);
        w_emit_evt.brk  = (r_state == BRK) || (r_state == EXT_BRK);
        w_emit_evt.code = w_byte;
    end

    // Register the emitted event so the FIFO write lands the cycle after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push     <= 1'b0;
            r_push_evt <= '0;
        end else begin
            r_push     <= w_emit;
            r_push_evt <= w_emit_evt;
        end
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign evt_valid = !w_empty;
    assign w_pop     = evt_valid && evt_ready;
    // A simultaneous pop frees the slot, so a push onto a full FIFO still succeeds.
    assign w_wr_en   = r_push && (!w_full || w_pop);
    assign w_ovf_set = r_push && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign evt_code  = w_head.code;
    assign evt_break = w_head.brk;
    assign evt_ext   = w_head.ext;

    // FIFO storage and pointers; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_push_evt;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (w_ovf_set)    overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (w_frame_err)  parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a keyboard model drives the PS/2 lines and
// every expected event is written out by hand.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       overflow;
    logic       parity_err;
    logic       clr_err;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_kbd_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_break  (evt_break),
        .evt_ext    (evt_ext),
        .overflow   (overflow),
        .parity_err (parity_err),
        .clr_err    (clr_err),
        .dbg_state  (dbg_state)
    );

    // 100 MHz system clock; the keyboard clock below runs at 80 ns (8 system clocks).
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bit i goes on the wire i-th: start 0, data LSB-first, odd parity, stop 1.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = frame[i];
            #20 ps2_clk = 1'b0;
            #40 ps2_clk = 1'b1;
            #20;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
        send_bits(mk_frame(b, bad_par), 11);
        #200;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (evt_valid) break;
        end
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] code, input logic brk,
                              input logic ext);
        wait_valid();
        chk({tag, "_valid"}, evt_valid, 1);
        chk({tag, "_code"}, evt_code, code);
        chk({tag, "_brk"}, evt_break, brk);
        chk({tag, "_ext"}, evt_ext, ext);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    logic seen_push;

    initial begin
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        evt_ready = 1'b0;
        clr_err   = 1'b0;
        seen_push = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_brk", evt_break, 0);
        chk("rst_ext", evt_ext, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: plain make code, held until accepted.
        send_byte(8'h1C);
        wait_valid();
        repeat (20) @(negedge clk);
        chk("t1_hold", evt_valid, 1);
        pop_expect("t1", 8'h1C, 1'b0, 1'b0);
        chk("t1_empty", evt_valid, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_perr", parity_err, 0);

        // 2: break, extended and extended-break sequences.
        send_byte(8'hF0);
        chk("t2_state_brk", dbg_state, 2);
        send_byte(8'h1C);
        send_byte(8'hE0);
        chk("t2_state_ext", dbg_state, 1);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        chk("t2_state_extbrk", dbg_state, 3);
        send_byte(8'h75);
        pop_expect("t2a", 8'h1C, 1'b1, 1'b0);
        pop_expect("t2b", 8'h75, 1'b0, 1'b1);
        pop_expect("t2c", 8'h75, 1'b1, 1'b1);
        chk("t2_empty", evt_valid, 0);

        // 3: bad parity frame is dropped and flagged, next frame still decodes.
        send_byte(8'h1C, 1'b1);
        chk("t3_perr_set", parity_err, 1);
        chk("t3_no_evt", evt_valid, 0);
        send_byte(8'h1B);
        pop_expect("t3", 8'h1B, 1'b0, 1'b0);
        chk("t3_empty", evt_valid, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t3_perr_clr", parity_err, 0);

        // 4: nine events into an eight-deep FIFO with no reader.
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
        chk("t4_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) pop_expect($sformatf("t4_%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0);
        chk("t4_empty", evt_valid, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_ovf_clr", overflow, 0);

        // 5: fill the FIFO, then pop exactly in the cycle the ninth push lands.
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
        chk("t5_full_ovf", overflow, 0);
        fork
            send_byte(8'h28);
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (dut.r_push) break;
                end
                seen_push = dut.r_push;
                chk("t5_head", evt_code, 8'h20);
                evt_ready = 1'b1;
                @(negedge clk);
                evt_ready = 1'b0;
            end
        join
        chk("t5_push_seen", seen_push, 1);
        chk("t5_ovf", overflow, 0);
        for (int i = 1; i < 9; i++) pop_expect($sformatf("t5_%0d", i), 8'h20 + 8'(i), 1'b0, 1'b0);
        chk("t5_empty", evt_valid, 0);

        // 6a: reset during a break prefix and half-received frame.
        send_byte(8'hF0);
        send_bits(mk_frame(8'h5A, 1'b0), 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_state", dbg_state, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(8'h29);
        pop_expect("t6a", 8'h29, 1'b0, 1'b0);
        chk("t6a_empty", evt_valid, 0);
        chk("t6a_ovf", overflow, 0);
        chk("t6a_perr", parity_err, 0);

        // 6b: keyboard stalls mid-frame longer than the timeout.
        send_bits(mk_frame(8'h33, 1'b0), 5);
        repeat (4200) @(negedge clk);
        send_byte(8'h2A);
        pop_expect("t6b", 8'h2A, 1'b0, 1'b0);
        chk("t6b_empty", evt_valid, 0);
        chk("t6b_perr", parity_err, 0);
        chk("t6b_ovf", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
